store_unit: RTL and testbench

STORE_UNIT -- requirements
Module: store_unit

---
 rtl/store_unit_pkg.sv | 17 +
 rtl/store_unit_if.sv | 11 +
 rtl/store_align.sv | 30 +++
 rtl/store_unit.sv | 127 ++++++++++++
 tb/tb_store_unit.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/store_unit_pkg.sv
// rtl/store_unit_pkg.sv - shared opcodes, exception codes and types for the store unit
package store_unit_pkg;

  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_LH = 6'b100001;
  localparam logic [5:0] OP_LB = 6'b100000;

  localparam logic [3:0] EXC_NONE = 4'd0;
  localparam logic [3:0] EXC_ADES = 4'd5;

  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_e;
  typedef enum logic {IDLE, BUSY} state_e;

endpackage

// File: rtl/store_unit_if.sv
// rtl/store_unit_if.sv - data-memory write bus between the store unit and memory
interface store_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  modport master (output mem_req, output mem_addr, output mem_wdata, output mem_be, input mem_ack);
  modport slave  (input mem_req, input mem_addr, input mem_wdata, input mem_be, output mem_ack);
endinterface

// File: rtl/store_align.sv
// rtl/store_align.sv - byte-enable generation and lane replication for sw/sh/sb
module store_align
  import store_unit_pkg::*;
(
  input  size_e       size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] aligned_addr,
  output logic [31:0] aligned_wdata,
  output logic [3:0]  be
);

  always_comb begin
    aligned_addr  = {addr[31:2], 2'b00};
    aligned_wdata = wdata;
    be            = 4'b1111;
    case (size)
      SZ_HALF: begin
        be            = addr[1] ? 4'b1100 : 4'b0011;
        aligned_wdata = {2{wdata[15:0]}};
      end
      SZ_BYTE: begin
        be            = 4'b0001 << addr[1:0];
        aligned_wdata = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - M-stage store unit driving a single-outstanding data-memory write bus
// STORE_BUF_EN: posted stores; only stores and same-word loads stall while a write is in flight.
module store_unit
  import store_unit_pkg::*;
#(
  parameter logic [31:0] DM_BASE  = 32'h0000_0000,
  parameter logic [31:0] DM_LIMIT = 32'h0000_2FFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instrM,
  input  logic                validM,
  input  logic [31:0]         addrM,
  input  logic [31:0]         wdataM,
  input  logic                req,
  store_unit_if.master        mem,
  output logic                stall,
  output logic [3:0]          ExcCodeS,
  output logic                excS
);

  logic [5:0]  op;
  logic        is_store;
  logic        is_load;
  logic        misaligned;
  logic        out_of_range;
  logic        accept;
  logic        busy;
  size_e       size;
  state_e      state;
  state_e      state_next;
  logic [31:0] al_addr;
  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        unused_bits;

  assign op = instrM[31:26];
  assign unused_bits = ^{instrM[25:0], is_load};

  always_comb begin
    is_store = 1'b0;
    is_load  = 1'b0;
    size     = SZ_WORD;
    if (validM) begin
      case (op)
        OP_SW: is_store = 1'b1;
        OP_SH: begin
          is_store = 1'b1;
          size     = SZ_HALF;
        end
        OP_SB: begin
          is_store = 1'b1;
          size     = SZ_BYTE;
        end
        OP_LW, OP_LH, OP_LB: is_load = 1'b1;
        default: ;
      endcase
    end
  end

  // Offset-from-base compare covers both window edges and avoids an always-false
  // "addr < 0" when DM_BASE is zero.
  assign misaligned   = ((size == SZ_WORD) && (addrM[1:0] != 2'b00)) ||
                        ((size == SZ_HALF) && addrM[0]);
  assign out_of_range = (addrM - DM_BASE) > (DM_LIMIT - DM_BASE);
  assign excS         = is_store && (misaligned || out_of_range);
  assign ExcCodeS     = excS ? EXC_ADES : EXC_NONE;

  assign busy = (state == BUSY);

`ifdef STORE_BUF_EN
  assign stall = busy && !mem.mem_ack &&
                 (is_store || (is_load && (addrM[31:2] == addr_q[31:2])));
`else
  assign stall = busy && !mem.mem_ack;
`endif

  assign accept = is_store && !excS && !req && !stall;

  store_align u_align (
    .size          (size),
    .addr          (addrM),
    .wdata         (wdataM),
    .aligned_addr  (al_addr),
    .aligned_wdata (al_wdata),
    .be            (al_be)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // An ack edge with a new accept reloads the registers and stays BUSY: no bubble.
  always_comb begin
    state_next  = state;
    mem.mem_req = 1'b0;
    case (state)
      IDLE: if (accept) state_next = BUSY;
      BUSY: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) state_next = accept ? BUSY : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
    end else if (accept) begin
      addr_q  <= al_addr;
      wdata_q <= al_wdata;
      be_q    <= al_be;
    end
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - directed bench with a transaction-level reference model of the store unit
module tb_store_unit;

  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] SH = 6'b101001;
  localparam logic [5:0] SB = 6'b101000;
  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] LH = 6'b100001;
  localparam logic [5:0] LB = 6'b100000;
`ifdef STORE_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic [31:0] instrM = 32'h0;
  logic        validM = 1'b0;
  logic [31:0] addrM  = 32'h0;
  logic [31:0] wdataM = 32'h0;
  logic        req    = 1'b0;
  logic        stall;
  logic [3:0]  ExcCodeS;
  logic        excS;

  int errors = 0;
  int checks = 0;

  bit          m_busy   = 1'b0;
  logic [31:0] m_addr   = 32'h0;
  logic [31:0] m_wdata  = 32'h0;
  logic [3:0]  m_be     = 4'h0;
  int          m_accepts  = 0;
  int          dut_done   = 0;
  int          req_cycles = 0;
  int          base;

  store_unit_if bus ();

  store_unit dut (
    .clk      (clk),
    .reset    (reset),
    .instrM   (instrM),
    .validM   (validM),
    .addrM    (addrM),
    .wdataM   (wdataM),
    .req      (req),
    .mem      (bus),
    .stall    (stall),
    .ExcCodeS (ExcCodeS),
    .excS     (excS)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int store_bytes(input logic v, input logic [31:0] ins);
    if (!v) return 0;
    case (ins[31:26])
      SW: return 4;
      SH: return 2;
      SB: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_ld(input logic v, input logic [31:0] ins);
    return v && (ins[31:26] == LW || ins[31:26] == LH || ins[31:26] == LB);
  endfunction

  // Reference model: one outstanding write, outputs derived from access size arithmetic.
  always @(negedge clk) begin
    int  n;
    bit  e_exc, e_stall, acc;
    if (!reset) begin
      m_busy  = 1'b0;
      m_addr  = 32'h0;
      m_wdata = 32'h0;
      m_be    = 4'h0;
    end
    n       = store_bytes(validM, instrM);
    e_exc   = (n != 0) && (((addrM % n) != 0) || (addrM > 32'h0000_2FFF));
    e_stall = m_busy && !bus.mem_ack &&
              (!BUF_EN || (n != 0) ||
               (is_ld(validM, instrM) && ((addrM >> 2) == (m_addr >> 2))));
    chk("mem_req",   bus.mem_req,   m_busy);
    chk("mem_addr",  bus.mem_addr,  m_addr);
    chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("mem_be",    bus.mem_be,    m_be);
    chk("stall",     stall,         e_stall);
    chk("excS",      excS,          e_exc);
    chk("ExcCodeS",  ExcCodeS,      e_exc ? 32'd5 : 32'd0);
    if (reset) begin
      if (bus.mem_req) req_cycles++;
      if (bus.mem_req && bus.mem_ack) dut_done++;
      acc = (n != 0) && !e_exc && !req && !e_stall;
      if (acc) begin
        m_busy  = 1'b1;
        m_addr  = addrM & ~32'h3;
        m_be    = 4'(((1 << n) - 1) << (addrM % 4));
        m_wdata = (n == 4) ? wdataM :
                  (n == 2) ? wdataM[15:0] * 32'h0001_0001 :
                             wdataM[7:0] * 32'h0101_0101;
        m_accepts++;
      end else if (m_busy && bus.mem_ack) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic step(input logic v, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] d, input logic r, input logic k);
    @(posedge clk);
    #1;
    validM      = v;
    instrM      = {op, 26'h2A5_A5A5};
    addrM       = a;
    wdataM      = d;
    req         = r;
    bus.mem_ack = k;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_ack = 1'b0;
    #1 reset = 1'b0;
    #11;
    chk("rst_mem_req", bus.mem_req,  0);
    chk("rst_addr",    bus.mem_addr, 0);
    chk("rst_be",      bus.mem_be,   0);
    chk("rst_stall",   stall,        0);
    @(posedge clk);
    #1 reset = 1'b1;

    // sb at 0x13, acked after two wait cycles
    step(1, SB, 32'h13, 32'h1234_56AB, 0, 0);
    base = req_cycles;
    step(0, 6'd0, 0, 0, 0, 0);
    chk("t1_req",   bus.mem_req,   1);
    chk("t1_addr",  bus.mem_addr,  32'h10);
    chk("t1_be",    bus.mem_be,    4'b1000);
    chk("t1_wdata", bus.mem_wdata, 32'hABAB_ABAB);
    step(0, 6'd0, 0, 0, 1, 0);
    step(0, 6'd0, 0, 0, 0, 1);
    step(0, 6'd0, 0, 0, 0, 0);
    chk("t1_idle",      bus.mem_req,       0);
    chk("t1_req_len",   req_cycles - base, 3);
    chk("t1_addr_kept", bus.mem_addr,      32'h10);

    // misaligned sh, then stray ack in IDLE
    step(1, SH, 32'h21, 32'h5555, 0, 0);
    chk("t2_exc",  excS,     1);
    chk("t2_code", ExcCodeS, 5);
    step(0, 6'd0, 0, 0, 0, 1);
    chk("t2_noreq", bus.mem_req, 0);
    step(0, 6'd0, 0, 0, 0, 0);
    chk("t2_noreq2", bus.mem_req, 0);

    // range limit and word alignment
    step(1, SW, 32'h3000, 32'h1, 0, 0);
    chk("t3_exc",  excS,     1);
    chk("t3_code", ExcCodeS, 5);
    step(1, SW, 32'h102, 32'h2, 0, 0);
    chk("t3_noreq",  bus.mem_req, 0);
    chk("t3_mis",    excS,        1);
    step(1, SW, 32'h2FFC, 32'hDEAD_BEEF, 0, 0);
    chk("t3_edge_ok",   excS,     0);
    chk("t3_edge_code", ExcCodeS, 0);
    step(0, 6'd0, 0, 0, 0, 1);
    chk("t3_req",  bus.mem_req,  1);
    chk("t3_addr", bus.mem_addr, 32'h2FFC);
    chk("t3_be",   bus.mem_be,   4'b1111);
    step(0, 6'd0, 0, 0, 0, 0);
    chk("t3_idle", bus.mem_req, 0);

    // back-to-back words, then upper halfword
    step(1, SW, 32'h100, 32'h1111_1111, 0, 0);
    step(1, SW, 32'h204, 32'h2222_2222, 0, 1);
    chk("t4_req1",  bus.mem_req,  1);
    chk("t4_addr1", bus.mem_addr, 32'h100);
    chk("t4_stall", stall,        0);
    step(0, 6'd0, 0, 0, 0, 0);
    chk("t4_req2",   bus.mem_req,   1);
    chk("t4_addr2",  bus.mem_addr,  32'h204);
    chk("t4_wdata2", bus.mem_wdata, 32'h2222_2222);
    step(0, 6'd0, 0, 0, 0, 1);
    step(1, SH, 32'h206, 32'h0000_BEEF, 0, 0);
    chk("t4_gap", bus.mem_req, 0);
    step(0, 6'd0, 0, 0, 0, 1);
    chk("t4_sh_be",    bus.mem_be,    4'b1100);
    chk("t4_sh_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
    chk("t4_sh_addr",  bus.mem_addr,  32'h204);
    step(0, 6'd0, 0, 0, 0, 0);

    // loads against an in-flight word
    step(1, SW, 32'h40, 32'hCAFE_F00D, 0, 0);
    step(1, LW, 32'h40, 0, 0, 0);
    chk("t5_ld_same", stall, 1);
    step(1, LW, 32'h80, 0, 0, 0);
    chk("t5_ld_other", stall, BUF_EN ? 0 : 1);
    step(1, SW, 32'h50, 32'h5, 0, 0);
    chk("t5_st_busy", stall, 1);
    step(1, SW, 32'h50, 32'h5, 0, 1);
    chk("t5_st_ack",  stall,        0);
    chk("t5_addr40",  bus.mem_addr, 32'h40);
    step(0, 6'd0, 0, 0, 0, 1);
    chk("t5_req50",  bus.mem_req,  1);
    chk("t5_addr50", bus.mem_addr, 32'h50);
    step(0, 6'd0, 0, 0, 0, 0);

    // flush and reset mid-transaction
    step(1, SW, 32'h60, 32'h66, 1, 0);
    chk("t6_flush_exc", excS, 0);
    step(0, 6'd0, 0, 0, 0, 0);
    chk("t6_flush_noreq", bus.mem_req, 0);
    step(1, SW, 32'h64, 32'h77, 0, 0);
    step(1, SW, 32'h68, 32'h88, 0, 0);
    chk("t6_busy",  bus.mem_req, 1);
    chk("t6_stall", stall,       1);
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_req",   bus.mem_req,   0);
    chk("t6_rst_stall", stall,         0);
    chk("t6_rst_addr",  bus.mem_addr,  0);
    chk("t6_rst_wdata", bus.mem_wdata, 0);
    @(posedge clk);
    #1;
    validM = 1'b0;
    reset  = 1'b1;
    step(0, 6'd0, 0, 0, 0, 0);
    chk("t6_no_retry1", bus.mem_req, 0);
    step(0, 6'd0, 0, 0, 0, 1);
    chk("t6_no_retry2", bus.mem_req, 0);
    step(0, 6'd0, 0, 0, 0, 0);
    chk("t6_no_retry3", bus.mem_req, 0);

    chk("model_accepts", m_accepts, 8);
    chk("dut_completed", dut_done,  7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
